// File: rtl/rb1_arbiter.sv
// Two-port round-robin arbiter for the RB1 32x8 register bank.
// Define RB1_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins all contention).
module rb1_arbiter #(
  parameter int MAX_BURST = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_rw,
  input  logic [4:0] m0_addr,
  input  logic [7:0] m0_wd,
  input  logic       m0_last,
  output logic       m0_gnt,
  output logic       m0_rvalid,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_rw,
  input  logic [4:0] m1_addr,
  input  logic [7:0] m1_wd,
  input  logic       m1_last,
  output logic       m1_gnt,
  output logic       m1_rvalid,
  output logic [7:0] m1_rdata,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic       req;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       last;
  } port_req_t;

  localparam logic [5:0] CAP = 6'(MAX_BURST);

  port_req_t [1:0] p;
  state_t          state, state_nx;
  logic [5:0]      bcnt;
  logic            own, acc, rel;
  logic            rd_pend, rd_port;

  assign p[0] = {m0_req, m0_rw, m0_addr, m0_wd, m0_last};
  assign p[1] = {m1_req, m1_rw, m1_addr, m1_wd, m1_last};

  assign own = (state == OWN1);
  assign acc = (state != IDLE) && p[own].req;
  // A dropped request releases without an access; otherwise last or cap ends the burst.
  assign rel = (state != IDLE) &&
               (!p[own].req || p[own].last || (bcnt + 6'd1 == CAP));

`ifndef RB1_ARB_FIXED_PRIO_EN
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rr_ptr <= 1'b0;
    else if (rel) rr_ptr <= ~own;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (p[0].req && p[1].req) begin
`ifdef RB1_ARB_FIXED_PRIO_EN
          state_nx = OWN0;
`else
          state_nx = rr_ptr ? OWN1 : OWN0;
`endif
        end else if (p[0].req) state_nx = OWN0;
        else if (p[1].req)     state_nx = OWN1;
      end
      default: begin
        if (rel) begin
`ifdef RB1_ARB_FIXED_PRIO_EN
          if (p[0].req)      state_nx = OWN0;
          else if (p[1].req) state_nx = OWN1;
          else               state_nx = IDLE;
`else
          // Other port first; the releasing port may re-grab only if alone.
          if (p[~own].req)     state_nx = own ? OWN0 : OWN1;
          else if (p[own].req) state_nx = state;
          else                 state_nx = IDLE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        bcnt <= '0;
    else if (rel || state == IDLE)   bcnt <= '0;
    else if (acc)                    bcnt <= bcnt + 6'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      rd_pend <= acc && p[own].rw;
      rd_port <= own;
    end
  end

  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign RB1_RW    = acc ? p[own].rw   : 1'b1;
  assign RB1_A     = acc ? p[own].addr : 5'd0;
  assign RB1_D     = acc ? p[own].wd   : 8'd0;
  assign m0_rvalid = rd_pend && !rd_port;
  assign m1_rvalid = rd_pend &&  rd_port;
  assign m0_rdata  = m0_rvalid ? RB1_Q : 8'd0;
  assign m1_rdata  = m1_rvalid ? RB1_Q : 8'd0;

endmodule

// File: tb/tb_rb1_arbiter.sv
// Directed table-driven bench for rb1_arbiter with a behavioural RB1 memory.
module tb_rb1_arbiter;

  logic       clk = 1'b0, rst = 1'b0;
  logic       m0_req, m0_rw, m0_last, m0_gnt, m0_rvalid;
  logic [4:0] m0_addr;
  logic [7:0] m0_wd, m0_rdata;
  logic       m1_req, m1_rw, m1_last, m1_gnt, m1_rvalid;
  logic [4:0] m1_addr;
  logic [7:0] m1_wd, m1_rdata;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D, RB1_Q;

`ifdef RB1_ARB_FIXED_PRIO_EN
  localparam int FP = 1;
`else
  localparam int FP = 0;
`endif
  localparam logic [15:0] NONE = '0;

  rb1_arbiter #(.MAX_BURST(18)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_last(m0_last),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_last(m1_last),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .RB1_RW(RB1_RW), .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q)
  );

  always #5 clk = ~clk;

  // RB1 model: write at the access edge, read data registered one cycle later.
  logic [7:0] mem [32];
  logic [7:0] q;
  always @(posedge clk) begin
    if (!RB1_RW) mem[RB1_A] <= RB1_D;
    q <= mem[RB1_A];
  end
  assign RB1_Q = q;

  typedef struct {
    string      nm;
    logic [15:0] i0, i1;
    logic       g0, g1, v0, v1, brw;
    logic [7:0] q0, q1, bd;
    logic [4:0] ba;
  } vec_t;

  vec_t vq[$];
  int checks = 0, errors = 0;

  function automatic int iv(input int i);
    return (8'h40 + 5 * i) & 255;
  endfunction

  function automatic logic [15:0] P(input int r, input int w, input int a, input int d, input int l);
    return {1'(r), 1'(w), 5'(a), 8'(d), 1'(l)};
  endfunction

  task automatic add(input string nm, input logic [15:0] i0, input logic [15:0] i1,
                     input int g0, input int g1, input int v0, input int q0,
                     input int v1, input int q1, input int brw, input int ba, input int bd);
    vec_t v;
    v.nm = nm; v.i0 = i0; v.i1 = i1;
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.v0 = 1'(v0); v.q0 = 8'(q0);
    v.v1 = 1'(v1); v.q1 = 8'(q1); v.brw = 1'(brw); v.ba = 5'(ba); v.bd = 8'(bd);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input vec_t v);
    chk({v.nm, " m0_gnt"},    8'(m0_gnt),    8'(v.g0));
    chk({v.nm, " m1_gnt"},    8'(m1_gnt),    8'(v.g1));
    chk({v.nm, " m0_rvalid"}, 8'(m0_rvalid), 8'(v.v0));
    chk({v.nm, " m0_rdata"},  m0_rdata,      v.q0);
    chk({v.nm, " m1_rvalid"}, 8'(m1_rvalid), 8'(v.v1));
    chk({v.nm, " m1_rdata"},  m1_rdata,      v.q1);
    chk({v.nm, " RB1_RW"},    8'(RB1_RW),    8'(v.brw));
    chk({v.nm, " RB1_A"},     8'(RB1_A),     8'(v.ba));
    chk({v.nm, " RB1_D"},     RB1_D,         v.bd);
  endtask

  task automatic drive(input logic [15:0] i0, input logic [15:0] i1);
    {m0_req, m0_rw, m0_addr, m0_wd, m0_last} = i0;
    {m1_req, m1_rw, m1_addr, m1_wd, m1_last} = i1;
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 32; i++) mem[i] = 8'(iv(i));
    drive(NONE, NONE);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rv = '{nm: "reset", i0: NONE, i1: NONE, g0: 0, g1: 0, v0: 0, v1: 0, brw: 1,
           q0: 0, q1: 0, bd: 0, ba: 0};
    check_out(rv);
    rst = 1'b1;

    // Contention right after reset: port 0 first, port 1 follows with no gap.
    add("both req",  P(1,1,1,0,0), P(1,1,20,0,1), 0,0, 0,0, 0,0, 1,0,0);
    add("both own0", P(1,1,1,0,0), P(1,1,20,0,1), 1,0, 0,0, 0,0, 1,1,0);
    add("both last0",P(1,1,2,0,1), P(1,1,20,0,1), 1,0, 1,iv(1), 0,0, 1,2,0);
    add("both hand1",NONE,         P(1,1,20,0,1), 0,1, 1,iv(2), 0,0, 1,20,0);
    add("both tail", NONE,         NONE,          0,1, 0,0, 1,iv(20), 1,0,0);
    add("both idle", NONE,         NONE,          0,0, 0,0, 0,0, 1,0,0);

    // 18-read burst from port 0 alone.
    add("burst req", P(1,1,0,0,0), NONE, 0,0, 0,0, 0,0, 1,0,0);
    for (int k = 1; k <= 18; k++)
      add("burst acc", P(1,1,k-1,0,(k==18)?1:0), NONE, 1,0,
          (k>=2)?1:0, (k>=2)?iv(k-2):0, 0,0, 1,k-1,0);
    add("burst tail", NONE, NONE, 1,0, 1,iv(17), 0,0, 1,0,0);
    add("burst idle", NONE, NONE, 0,0, 0,0, 0,0, 1,0,0);

    // Port 1 write then read-back of address 7.
    add("wr req",   NONE, P(1,0,7,8'hA5,1), 0,0, 0,0, 0,0, 1,0,0);
    add("wr acc",   NONE, P(1,0,7,8'hA5,1), 0,1, 0,0, 0,0, 0,7,8'hA5);
    add("rd acc",   NONE, P(1,1,7,0,1),     0,1, 0,0, 0,0, 1,7,0);
    add("rd data",  NONE, NONE,             0,1, 0,0, 1,8'hA5, 1,0,0);
    add("wr idle",  NONE, NONE,             0,0, 0,0, 0,0, 1,0,0);

    // Repeated single accesses under contention.
    add("alt req", P(1,1,3,0,1), P(1,1,4,0,1), 0,0, 0,0, 0,0, 1,0,0);
    add("alt c1",  P(1,1,3,0,1), P(1,1,4,0,1), 1,0, 0,0, 0,0, 1,3,0);
    add("alt c2",  P(1,1,3,0,1), P(1,1,4,0,1), FP,1-FP, 1,iv(3), 0,0, 1,FP?3:4,0);
    add("alt c3",  P(1,1,3,0,1), P(1,1,4,0,1), 1,0, FP,FP?iv(3):0, 1-FP,FP?0:iv(4), 1,3,0);
    add("alt c4",  P(1,1,3,0,1), P(1,1,4,0,1), FP,1-FP, 1,iv(3), 0,0, 1,FP?3:4,0);
    add("alt c5",  NONE,         P(1,1,4,0,1), 1,0, FP,FP?iv(3):0, 1-FP,FP?0:iv(4), 1,0,0);
    add("alt c6",  NONE,         P(1,1,4,0,1), 0,1, 0,0, 0,0, 1,4,0);
    add("alt c7",  NONE,         NONE,         0,1, 0,0, 1,iv(4), 1,0,0);
    add("alt idle",NONE,         NONE,         0,0, 0,0, 0,0, 1,0,0);

`ifndef RB1_ARB_FIXED_PRIO_EN
    // Burst cap: port 0 streams without last, port 1 cuts in after 18 accesses.
    add("cap req", P(1,1,8,0,0), P(1,1,30,0,1), 0,0, 0,0, 0,0, 1,0,0);
    for (int k = 1; k <= 18; k++)
      add("cap own0", P(1,1,8+k-1,0,0), P(1,1,30,0,1), 1,0,
          (k>=2)?1:0, (k>=2)?iv(8+k-2):0, 0,0, 1,8+k-1,0);
    add("cap hand1",  P(1,1,26,0,0), P(1,1,30,0,1), 0,1, 1,iv(25), 0,0, 1,30,0);
    add("cap resume", P(1,1,26,0,0), NONE,          1,0, 0,0, 1,iv(30), 1,26,0);
    add("cap last0",  P(1,1,27,0,1), NONE,          1,0, 1,iv(26), 0,0, 1,27,0);
    add("cap tail",   NONE,          NONE,          1,0, 1,iv(27), 0,0, 1,0,0);
    add("cap idle",   NONE,          NONE,          0,0, 0,0, 0,0, 1,0,0);
`endif

    foreach (vq[n]) begin
      @(posedge clk); #1;
      drive(vq[n].i0, vq[n].i1);
      @(negedge clk);
      check_out(vq[n]);
    end

    // Reset asserted mid-burst with a read pending.
    @(posedge clk); #1 drive(P(1,1,0,0,0), NONE);
    @(posedge clk); #1;
    @(negedge clk); chk("rst pre gnt", 8'(m0_gnt), 8'd1);
    @(posedge clk); #1 drive(P(1,1,1,0,0), NONE);
    @(negedge clk);
    chk("rst pre rvalid", 8'(m0_rvalid), 8'd1);
    chk("rst pre rdata",  m0_rdata, 8'(iv(0)));
    #1 rst = 1'b0;
    #1;
    chk("rst m0_gnt",    8'(m0_gnt),    8'd0);
    chk("rst m0_rvalid", 8'(m0_rvalid), 8'd0);
    chk("rst m0_rdata",  m0_rdata,      8'd0);
    chk("rst RB1_RW",    8'(RB1_RW),    8'd1);
    chk("rst RB1_A",     8'(RB1_A),     8'd0);
    @(posedge clk); #1;
    chk("rst hold gnt",  8'(m0_gnt),    8'd0);
    @(negedge clk); rst = 1'b1; drive(NONE, NONE);
    @(posedge clk); #1 drive(P(1,1,5,0,1), P(1,1,6,0,1));
    @(negedge clk);
    chk("post rst idle0", 8'(m0_gnt), 8'd0);
    chk("post rst idle1", 8'(m1_gnt), 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post rst win0",  8'(m0_gnt), 8'd1);
    chk("post rst lose1", 8'(m1_gnt), 8'd0);
    chk("post rst addr",  8'(RB1_A),  8'd5);
    @(posedge clk); #1 drive(NONE, NONE);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb1_arbiter.md
# rb1_arbiter

Two-port arbiter in front of the single-port 32x8 register bank RB1. Two requesters share it: port 0 (column serializer, read bursts) and port 1 (loader/host, reads and writes). The block grants RB1 to one port at a time with round-robin fairness, burst locking and a burst-length cap. It drives the RB1 control/data pins and routes read data back to the issuing port.

## Interface
Parameters:
- MAX_BURST, 18, max consecutive accesses per grant (1..32)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  port 0 access request, level
- m0_rw  in  1  1 = read, 0 = write (RB1_RW convention)
- m0_addr  in  5  access address
- m0_wd  in  8  write data
- m0_last  in  1  final access of this burst
- m0_gnt  out  1  port 0 owns RB1
- m0_rvalid  out  1  m0_rdata valid
- m0_rdata  out  8  read data
- m1_req, m1_rw, m1_addr, m1_wd, m1_last, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- RB1_RW  out  1  RB1 read/write (1 = read)
- RB1_A  out  5  RB1 address
- RB1_D  out  8  RB1 write data
- RB1_Q  in  8  RB1 read data, valid the cycle after the address

## Operation
- States: IDLE, OWN0, OWN1. m0_gnt = (state==OWN0), m1_gnt = (state==OWN1), both registered.
- IDLE: neither req -> stay. One req -> OWNx. Both -> port at rr_ptr.
- Access: every cycle in OWNx with mx_req=1. RB1_RW/A/D are combinational muxes of port x's rw/addr/wd. With no access: RB1_RW=1, RB1_A=0, RB1_D=0.
- Burst counter bcnt (6 bit) clears on grant and increments per access.
- Release after an access with mx_last=1 or bcnt+1==MAX_BURST, or when mx_req=0 in OWNx (no access that cycle). On release, rr_ptr = other port. The next state is chosen from the requests seen that cycle: other port's req -> OWN(other); else own req still high -> OWNx with bcnt cleared; else IDLE.
- Read return: rd_pend/rd_port registered on each read access. Next cycle, mx_rvalid=1 for rd_port only, and mx_rdata=RB1_Q. The other port's rdata is 0.
- A write completes at the access edge. It produces no rvalid.
- Requester rule: hold req/rw/addr/wd stable until the gnt cycle. Signals sampled while gnt=0 are ignored.

## Timing
- Reset (rst=0, async): state IDLE, rr_ptr=0, bcnt=0, m0/m1_gnt=0, m0/m1_rvalid=0, rdata=0, RB1_RW=1, RB1_A=0, RB1_D=0.
- req high at edge t in IDLE -> gnt high after t+1. First access is in cycle t+1. Read data comes with rvalid in cycle t+2.
- Streaming: one access per cycle while granted. An N-access read burst yields N consecutive rvalid cycles.
- Handover: the release cycle and the new owner's first access are adjacent cycles, with no idle cycle.
- Cap: at MAX_BURST accesses, the grant moves to the other port if it is requesting. The capped port resumes after the other port's burst ends. Its bcnt restarts from 0.
- Reset mid-burst: the grant is dropped and any pending rvalid is discarded. RB1 goes to idle values immediately.
- Simultaneous first requests after reset: port 0 wins (rr_ptr=0).

## Configuration
- RB1_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins any contention. rr_ptr is unused. The MAX_BURST cap still forces release, and port 1 is granted only if port 0 is not requesting.
- Undefined (default): round-robin as described.

## Test plan
- Port 0 reads addr 0..17 with m0_last on the 18th access, port 1 idle -> 18 back-to-back accesses, RB1_A 0..17, 18 m0_rvalid cycles carrying RB1_Q, then IDLE.
- Port 1 writes 0xA5 to addr 7, then reads addr 7 -> RB1_RW=0 with RB1_D=0xA5 in the write cycle. The next read returns 0xA5 with m1_rvalid one cycle after the access.
- Both ports request from IDLE after reset -> port 0 granted first. After port 0's last access, port 1 is granted on the next cycle with no gap.
- MAX_BURST=4, port 0 streams 10 reads without last while port 1 requests -> port 0 gets 4 accesses, then port 1's burst, then port 0 resumes at its 5th address.
- Drive rst low during a read burst with a read pending -> gnt and rvalid go to 0 immediately. After release, the arbiter is IDLE and port 0 wins the next contention.
- With RB1_ARB_FIXED_PRIO_EN, both ports repeatedly issue single accesses (last=1) -> port 0 always wins. Port 1 is granted only in cycles where m0_req=0.
